att_pd_axis: RTL and testbench



---
 rtl/att_pd_axis_if.sv | 22 ++
 rtl/att_pd_axis.sv | 144 ++++++++++++++
 tb/tb_att_pd_axis.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/att_pd_axis_if.sv
// Sample/result bundle for one attitude PD axis: angle sample in, P/D terms out.
interface att_pd_axis_if;
  logic               vld;
  logic signed [15:0] angle;
  logic signed [15:0] d_angle;
  logic signed [13:0] pterm;
  logic signed [13:0] dterm;
  logic signed [13:0] pd_out;
  logic               out_vld;

  // PD stage side
  modport slave (
    input  vld, angle, d_angle,
    output pterm, dterm, pd_out, out_vld
  );

  // Inertial interface / consumer side
  modport master (
    output vld, angle, d_angle,
    input  pterm, dterm, pd_out, out_vld
  );
endinterface

// File: rtl/att_pd_axis.sv
// Single-axis attitude PD stage. Each vld sample forms a saturated angle
// error; the D term compares it against the error D_DEPTH samples back.
// Two register stages: error/difference, then P/D/sum with a one-cycle strobe.
module att_pd_axis #(
  parameter int D_DEPTH = 12,
  parameter int P_NUM   = 5,
  parameter int D_COEFF = 7
) (
  input logic          clk,
  input logic          rst,
  att_pd_axis_if.slave bus
);

  localparam int DATA_W = 16;
  localparam int DIFF_W = DATA_W + 1;
  localparam int ERR_W  = 10;
  localparam int DD_W   = 7;
  localparam int OUT_W  = 14;

  localparam logic signed [DIFF_W-1:0] ERR_MAX = DIFF_W'(511);
  localparam logic signed [DIFF_W-1:0] ERR_MIN = -DIFF_W'(512);
  localparam logic signed [ERR_W:0]    DD_MAX  = (ERR_W+1)'(63);
  localparam logic signed [ERR_W:0]    DD_MIN  = -(ERR_W+1)'(64);
  localparam logic signed [OUT_W-1:0] P_K     = OUT_W'(P_NUM);
  localparam logic signed [OUT_W-1:0] D_K     = OUT_W'(D_COEFF);

  // Clamp the 17-bit angle error to the 10-bit error range.
  function automatic logic signed [ERR_W-1:0] sat_err(input logic signed [DIFF_W-1:0] x);
    logic signed [ERR_W-1:0] r;
    if (x > ERR_MAX)      r = ERR_W'(511);
    else if (x < ERR_MIN) r = -ERR_W'(512);
    else                  r = x[ERR_W-1:0];
    return r;
  endfunction

  // Clamp the 11-bit error difference to the 7-bit derivative range.
  function automatic logic signed [DD_W-1:0] sat_dd(input logic signed [ERR_W:0] x);
    logic signed [DD_W-1:0] r;
    if (x > DD_MAX)      r = DD_W'(63);
    else if (x < DD_MIN) r = -DD_W'(64);
    else                 r = x[DD_W-1:0];
    return r;
  endfunction

  // P term: err*P_NUM/8 with an arithmetic shift (floor toward -inf).
  function automatic logic signed [OUT_W-1:0] p_scale(input logic signed [ERR_W-1:0] e);
    logic signed [OUT_W-1:0] ex;
    logic signed [OUT_W-1:0] prod;
    ex   = {{(OUT_W-ERR_W){e[ERR_W-1]}}, e};
    prod = ex * P_K;
    return prod >>> 3;
  endfunction

  // D term: saturated difference times the signed D gain.
  function automatic logic signed [OUT_W-1:0] d_scale(input logic signed [DD_W-1:0] d);
    logic signed [OUT_W-1:0] dx;
    dx = {{(OUT_W-DD_W){d[DD_W-1]}}, d};
    return dx * D_K;
  endfunction

  // Error history: queue[0] newest, queue[D_DEPTH-1] oldest.
  logic signed [ERR_W-1:0]  queue [D_DEPTH];

  logic signed [DIFF_W-1:0] err_p0;
  logic signed [ERR_W-1:0]  err_sat_p0;
  logic signed [ERR_W:0]    d_diff_p0;
  logic signed [DD_W-1:0]   d_sat_p0;

  logic                     vld_p1;
  logic signed [ERR_W-1:0]  err_sat_p1;
  logic signed [DD_W-1:0]   d_sat_p1;

  logic                     vld_p2;
  logic signed [OUT_W-1:0]  pterm_p2;
  logic signed [OUT_W-1:0]  dterm_p2;
  logic signed [OUT_W-1:0]  pd_p2;

  logic signed [OUT_W-1:0]  pterm_nx;
  logic signed [OUT_W-1:0]  dterm_nx;

  // Stage 0 -> 1: error in 17 bits so +/-32768 inputs cannot wrap before clamping.
  always_comb begin
    err_p0     = $signed({bus.angle[DATA_W-1], bus.angle})
               - $signed({bus.d_angle[DATA_W-1], bus.d_angle});
    err_sat_p0 = sat_err(err_p0);
    d_diff_p0  = $signed({err_sat_p0[ERR_W-1], err_sat_p0})
               - $signed({queue[D_DEPTH-1][ERR_W-1], queue[D_DEPTH-1]});
    d_sat_p0   = sat_dd(d_diff_p0);
  end

  // Shift the newest saturated error into the history on every sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < D_DEPTH; i++) queue[i] <= '0;
    end else if (bus.vld) begin
      queue[0] <= err_sat_p0;
      for (int i = 1; i < D_DEPTH; i++) queue[i] <= queue[i-1];
    end
  end

  // Stage 1 registers: saturated error and saturated difference.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1     <= 1'b0;
      err_sat_p1 <= '0;
      d_sat_p1   <= '0;
    end else begin
      vld_p1 <= bus.vld;
      if (bus.vld) begin
        err_sat_p1 <= err_sat_p0;
        d_sat_p1   <= d_sat_p0;
      end
    end
  end

  // Stage 1 -> 2: gain scaling.
  always_comb begin
    pterm_nx = p_scale(err_sat_p1);
    dterm_nx = d_scale(d_sat_p1);
  end

  // Stage 2 registers: outputs hold between strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p2   <= 1'b0;
      pterm_p2 <= '0;
      dterm_p2 <= '0;
      pd_p2    <= '0;
    end else begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        pterm_p2 <= pterm_nx;
        dterm_p2 <= dterm_nx;
        pd_p2    <= pterm_nx + dterm_nx;
      end
    end
  end

  assign bus.pterm   = pterm_p2;
  assign bus.dterm   = dterm_p2;
  assign bus.pd_out  = pd_p2;
  assign bus.out_vld = vld_p2;

endmodule

// File: tb/tb_att_pd_axis.sv
// Bench for att_pd_axis: directed plan steps then random traffic, every cycle
// compared with an integer model of the error history and gain arithmetic.
module tb_att_pd_axis;
  localparam int D_DEPTH = 12;
  localparam int P_NUM   = 5;
  localparam int D_COEFF = 7;

  logic clk;
  logic rst;
  att_pd_axis_if ifc();

  att_pd_axis #(.D_DEPTH(D_DEPTH), .P_NUM(P_NUM), .D_COEFF(D_COEFF)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model state
  int hist[$];
  int pend_vld = 0, pend_p = 0, pend_d = 0, pend_o = 0;
  int exp_vld = 0, exp_p = 0, exp_d = 0, exp_o = 0;

  function automatic int clamp(input int x, input int lo, input int hi);
    return (x < lo) ? lo : ((x > hi) ? hi : x);
  endfunction

  function automatic int floor_div8(input int x);
    int q;
    q = x / 8;
    if ((x % 8 != 0) && (x < 0)) q = q - 1;
    return q;
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, let the edge pass, update model, compare all outputs.
  task automatic cycle(input bit v, input int a, input int d, input bit r, input string tag);
    int e, old, dd;
    rst         = r;
    ifc.vld     = v;
    ifc.angle   = 16'(a);
    ifc.d_angle = 16'(d);
    @(posedge clk);
    #1;
    if (r) begin
      hist.delete();
      pend_vld = 0;
      exp_vld = 0; exp_p = 0; exp_d = 0; exp_o = 0;
    end else begin
      exp_vld = pend_vld;
      if (pend_vld != 0) begin
        exp_p = pend_p; exp_d = pend_d; exp_o = pend_o;
      end
      pend_vld = 0;
      if (v) begin
        e   = clamp(a - d, -512, 511);
        old = (hist.size() == D_DEPTH) ? hist[0] : 0;
        dd  = clamp(e - old, -64, 63);
        hist.push_back(e);
        if (hist.size() > D_DEPTH) void'(hist.pop_front());
        pend_vld = 1;
        pend_p   = floor_div8(e * P_NUM);
        pend_d   = dd * D_COEFF;
        pend_o   = pend_p + pend_d;
      end
    end
    chk({tag, ".out_vld"}, int'(ifc.out_vld), exp_vld);
    chk({tag, ".pterm"},   int'(ifc.pterm),   exp_p);
    chk({tag, ".dterm"},   int'(ifc.dterm),   exp_d);
    chk({tag, ".pd_out"},  int'(ifc.pd_out),  exp_o);
  endtask

  task automatic do_reset();
    cycle(0, 0, 0, 1, "rst");
    cycle(0, 0, 0, 1, "rst");
  endtask

  task automatic chk_out(input string tag, input int p, input int d, input int o);
    chk({tag, ".vld"}, int'(ifc.out_vld), 1);
    chk({tag, ".p"},   int'(ifc.pterm),   p);
    chk({tag, ".d"},   int'(ifc.dterm),   d);
    chk({tag, ".o"},   int'(ifc.pd_out),  o);
  endtask

  initial begin
    int a, d;
    bit v, r;
    rst = 1'b1; ifc.vld = 1'b0; ifc.angle = '0; ifc.d_angle = '0;

    // 1: reset with vld held high, then idle after release
    cycle(1, 1000, 0, 1, "t1_rst");
    cycle(1, 1000, 0, 1, "t1_rst");
    chk("t1_zero_p", int'(ifc.pterm), 0);
    cycle(0, 0, 0, 0, "t1_idle");
    cycle(0, 0, 0, 0, "t1_idle");

    // 2: single sample
    cycle(1, 100, 0, 0, "t2_in");
    cycle(0, 0, 0, 0, "t2_out");
    chk_out("t2", 62, 441, 503);
    cycle(0, 0, 0, 0, "t2_hold");
    chk("t2_strobe_low", int'(ifc.out_vld), 0);

    // 3: positive and negative saturation
    do_reset();
    cycle(1, 28672, -1000, 0, "t3p_in");
    cycle(0, 0, 0, 0, "t3p_out");
    chk_out("t3p", 319, 441, 760);
    do_reset();
    cycle(1, -2000, 0, 0, "t3n_in");
    cycle(0, 0, 0, 0, "t3n_out");
    chk_out("t3n", -320, -448, -768);
    do_reset();
    cycle(1, 32767, -32768, 0, "t3x_in");
    cycle(0, 0, 0, 0, "t3x_out");
    chk_out("t3x", 319, 441, 760);
    cycle(1, -32768, 32767, 0, "t3y_in");
    cycle(0, 0, 0, 0, "t3y_out");
    chk_out("t3y", -320, -448, -768);

    // 4: steady error, derivative vanishes once the history wraps
    do_reset();
    for (int k = 1; k <= 13; k++) begin
      cycle(1, 100, 0, 0, "t4_in");
      cycle(0, 0, 0, 0, "t4_out");
      if (k <= 12) chk_out("t4_prime", 62, 441, 503);
      else         chk_out("t4_wrap", 62, 0, 62);
      for (int j = 0; j < 3; j++) cycle(0, 0, 0, 0, "t4_gap");
    end

    // 5: back-to-back samples
    do_reset();
    cycle(1, 10, 0, 0, "t5_in");
    cycle(1, 20, 0, 0, "t5_in");
    chk_out("t5a", 6, 70, 76);
    cycle(1, 30, 0, 0, "t5_in");
    chk_out("t5b", 12, 140, 152);
    cycle(0, 0, 0, 0, "t5_out");
    chk_out("t5c", 18, 210, 228);
    cycle(0, 0, 0, 0, "t5_end");

    // 6: reset while a sample is in flight
    do_reset();
    cycle(1, 100, 0, 0, "t6_in");
    cycle(0, 0, 0, 1, "t6_kill");
    chk("t6_no_strobe", int'(ifc.out_vld), 0);
    cycle(0, 0, 0, 0, "t6_idle");
    cycle(1, 100, 0, 0, "t6_in2");
    cycle(0, 0, 0, 0, "t6_out");
    chk_out("t6", 62, 441, 503);

    // 7: random traffic, occasional reset, mixed small and extreme errors
    do_reset();
    for (int n = 0; n < 600; n++) begin
      v = ($urandom_range(0, 99) < 60);
      r = ($urandom_range(0, 99) < 2);
      d = int'($urandom_range(0, 2000)) - 1000;
      case ($urandom_range(0, 7))
        0:       a = ($urandom_range(0, 1) != 0) ? 32767 : -32768;
        1:       a = int'($urandom_range(0, 65535)) - 32768;
        default: a = d + int'($urandom_range(0, 1300)) - 650;
      endcase
      cycle(v, a, d, r, "rand");
    end
    cycle(0, 0, 0, 0, "rand_drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
